// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_pkg                                                         |
// | Shared types and constants for the systolic array sequencer.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package systolic_pkg;

    localparam int DIM_W      = 5;
    localparam int MIN_DIM_M1 = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_seq_ctrl_phase_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_counter                                                        |
// | Row counter that wraps to zero on an increment at the programmed max.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module phase_counter #(
    parameter int DIM_W = systolic_pkg::DIM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [DIM_W-1:0] max,
    output logic [DIM_W-1:0] value,
    output logic             is_max
);

    logic [DIM_W-1:0] r_value;
    logic             w_at_max;

    assign w_at_max = (r_value == max);

    // Equality wrap keeps max = all-ones clean without relying on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= w_at_max ? '0 : r_value + 1'b1;
        end
    end

    assign value  = r_value;
    assign is_max = w_at_max;

endmodule
`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_seq_ctrl                                                    |
// | Weight-load / stream / drain sequencer for the DiP systolic array.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module systolic_seq_ctrl #(
    parameter int DIM_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_dim,
    input  logic             abort,
    input  logic             in_avail,
    input  logic             out_ready,
    output logic             busy,
    output logic             cfg_err,
    output logic             w_load_en,
    output logic             in_valid,
    output logic             out_valid,
    output logic [DIM_W-1:0] row_idx,
    output logic             array_en,
    output logic             acc_clear,
    output logic             done
);

    import systolic_pkg::*;

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [DIM_W-1:0] r_dim_q;
    logic             r_cfg_err;
    logic             r_acc_clear;
    logic             w_idle;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_abort;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [DIM_W-1:0] w_cnt_value;
    logic             w_cnt_is_max;

    assign w_idle      = (r_state == IDLE);
    assign w_start_ok  = w_idle && start && (cfg_dim >= DIM_W'(MIN_DIM_M1));
    assign w_start_bad = w_idle && start && (cfg_dim <  DIM_W'(MIN_DIM_M1));
    assign w_abort     = abort && !w_idle;

    assign w_cnt_clr = w_start_ok || w_abort;
    assign w_cnt_inc = (r_state == LOAD_W)
                    || ((r_state == COMPUTE) && in_avail)
                    || ((r_state == DRAIN)   && out_ready);

    phase_counter #(
        .DIM_W (DIM_W)
    ) u_phase_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_cnt_clr),
        .inc    (w_cnt_inc),
        .max    (r_dim_q),
        .value  (w_cnt_value),
        .is_max (w_cnt_is_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok)                    w_next_state = LOAD_W;
            LOAD_W:  if (w_cnt_is_max)                  w_next_state = COMPUTE;
            COMPUTE: if (in_avail && w_cnt_is_max)      w_next_state = DRAIN;
            DRAIN:   if (out_ready && w_cnt_is_max)     w_next_state = DONE;
            DONE:                                       w_next_state = IDLE;
            default:                                    w_next_state = IDLE;
        endcase
        // Cancel outranks every phase transition, including the DONE exit.
        if (w_abort) begin
            w_next_state = IDLE;
        end
    end

    // Job dimension is frozen at start so host-side cfg_dim churn is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dim_q     <= '0;
            r_cfg_err   <= 1'b0;
            r_acc_clear <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_dim_q <= cfg_dim;
            end
            r_cfg_err   <= w_start_bad;
            r_acc_clear <= w_start_ok;
        end
    end

    always_comb begin
        busy      = !w_idle;
        cfg_err   = r_cfg_err;
        acc_clear = r_acc_clear;
        w_load_en = 1'b0;
        in_valid  = 1'b0;
        out_valid = 1'b0;
        array_en  = 1'b0;
        done      = 1'b0;
        row_idx   = w_cnt_value;
        case (r_state)
            LOAD_W: begin
                w_load_en = 1'b1;
                array_en  = 1'b1;
            end
            COMPUTE: begin
                in_valid = in_avail;
                array_en = in_avail;
            end
            DRAIN: begin
                out_valid = 1'b1;
                array_en  = out_ready;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_systolic_seq_ctrl                                                 |
// | Vector table, row-event scoreboard and corner-case sequences.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/100ps
module tb_systolic_seq_ctrl;

    localparam int DW = 5;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [DW-1:0] cfg_dim   = '0;
    logic          abort     = 1'b0;
    logic          in_avail  = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, cfg_err, w_load_en, in_valid, out_valid;
    logic          array_en, acc_clear, done;
    logic [DW-1:0] row_idx;
    logic [12:0]   obs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.DIM_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_dim   (cfg_dim),
        .abort     (abort),
        .in_avail  (in_avail),
        .out_ready (out_ready),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .w_load_en (w_load_en),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .row_idx   (row_idx),
        .array_en  (array_en),
        .acc_clear (acc_clear),
        .done      (done)
    );

    assign obs = {busy, cfg_err, w_load_en, in_valid, out_valid, array_en, acc_clear, done, row_idx};

    function automatic logic [12:0] mk(input logic b, input logic ce, input logic wl, input logic iv,
                                       input logic ov, input logic ae, input logic ac, input logic dn,
                                       input logic [4:0] row);
        return {b, ce, wl, iv, ov, ae, ac, dn, row};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Row-event scoreboard: kind 0=weight, 1=input, 2=output, 3=done.
    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] row;
    } ev_t;

    ev_t sb[$];
    ev_t mon_got;
    ev_t mon_exp;

    task automatic push_job(input int n);
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < n; r++) begin
                sb.push_back({2'(k), 5'(r)});
            end
        end
        sb.push_back({2'd3, 5'd0});
    endtask

    always @(negedge clk) begin
        if (rst_n && (w_load_en || in_valid || (out_valid && out_ready) || done)) begin
            mon_got.kind = w_load_en ? 2'd0 : in_valid ? 2'd1 : (out_valid && out_ready) ? 2'd2 : 2'd3;
            mon_got.row  = row_idx;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_event: got 0x%0h, expected no event", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                check("sb_row_event", int'(mon_got), int'(mon_exp));
            end
        end
    end

    task automatic drive(input logic s, input logic [4:0] d, input logic ia, input logic orr, input logic ab);
        @(posedge clk);
        #1;
        start     = s;
        cfg_dim   = d;
        in_avail  = ia;
        out_ready = orr;
        abort     = ab;
        #1;
    endtask

    // One job from its start cycle (cycle 0) to the first IDLE cycle after done.
    task automatic run_job(input string name, input logic [4:0] dim, input int exp_done,
                           input bit skip_start, input int ia_s, input int ia_n, input logic [4:0] ia_row,
                           input int or_s, input int or_n, input logic [4:0] or_row, input int xs);
        int          done_at;
        logic        ia, orr;
        logic [4:0]  d;
        done_at = -1;
        if (!skip_start) begin
            push_job(int'(dim) + 1);
            drive(1'b1, dim, 1'b1, 1'b1, 1'b0);
        end
        for (int k = 1; k <= exp_done + 10 && done_at < 0; k++) begin
            ia  = !(k >= ia_s && k < ia_s + ia_n);
            orr = !(k >= or_s && k < or_s + or_n);
            d   = (xs > 0 && k >= xs) ? 5'd7 : dim;
            drive(xs > 0 && k == xs, d, ia, orr, 1'b0);
            if (!ia)
                check({name, "_in_stall"}, {array_en, in_valid, row_idx}, {2'b00, ia_row});
            if (!orr)
                check({name, "_out_stall"}, {array_en, out_valid, row_idx}, {2'b01, or_row});
            if (done)
                done_at = k;
        end
        check({name, "_done_cycle"}, done_at, exp_done);
        drive(1'b0, dim, 1'b1, 1'b1, 1'b0);
        check({name, "_idle_after"}, obs, 0);
    endtask

    typedef struct {
        logic       start;
        logic [4:0] dim;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal N=4 timeline; cycle 14 is the first IDLE cycle and starts a second job.
        for (int c = 0; c < 15; c++) begin
            tbl[c].start = (c == 0) || (c == 14);
            tbl[c].dim   = 5'd3;
            if (c >= 1 && c <= 4)
                tbl[c].exp = mk(1, 0, 1, 0, 0, 1, c == 1, 0, 5'(c - 1));
            else if (c >= 5 && c <= 8)
                tbl[c].exp = mk(1, 0, 0, 1, 0, 1, 0, 0, 5'(c - 5));
            else if (c >= 9 && c <= 12)
                tbl[c].exp = mk(1, 0, 0, 0, 1, 1, 0, 0, 5'(c - 9));
            else if (c == 13)
                tbl[c].exp = mk(1, 0, 0, 0, 0, 0, 0, 1, 5'd0);
            else
                tbl[c].exp = '0;
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs, 0);
        rst_n = 1'b1;

        push_job(4);
        for (int c = 0; c < 15; c++) begin
            if (c == 14)
                push_job(4);
            drive(tbl[c].start, tbl[c].dim, 1'b1, 1'b1, 1'b0);
            check($sformatf("nominal_c%0d", c), obs, tbl[c].exp);
        end
        run_job("back_to_back", 5'd3, 13, 1'b1, 0, 0, 5'd0, 0, 0, 5'd0, 0);

        run_job("stall", 5'd3, 18, 1'b0, 6, 2, 5'd1, 13, 3, 5'd2, 0);

        drive(1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        check("illegal_c0", obs, 0);
        drive(1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
        check("illegal_cfg_err", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd0));
        drive(1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
        check("illegal_c2", obs, 0);
        run_job("after_illegal", 5'd3, 13, 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 0);

        // Abort alongside start in IDLE must not block the job.
        push_job(4);
        drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 6; k++)
            drive(1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
        check("abort_cycle_row", {busy, in_valid, row_idx}, {2'b11, 5'd2});
        @(negedge clk);
        #1;
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
            check($sformatf("abort_idle_%0d", k), obs, 0);
        end
        run_job("after_abort", 5'd3, 13, 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 0);

        run_job("max_dim", 5'd31, 97, 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 5);

        push_job(4);
        drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++)
            drive(1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        check("pre_reset_drain", obs, mk(1, 0, 0, 0, 1, 1, 0, 0, 5'd0));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", obs, 0);
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_job("after_reset", 5'd3, 13, 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 0);

        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
